// File: rtl/press_qualifier.sv
// Push-button input stage: synchronises and debounces a raw button into the
// level `w`, and qualifies each press with `n` when it begins inside the
// response window opened by `prompt`.
module press_qualifier #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000,
   parameter int unsigned WINDOW_CYCLES   = 5000
) (
   input  logic clock,
   input  logic reset,
   input  logic button_raw,
   input  logic prompt,
   output logic w,
   output logic n,
   output logic window_active,
   output logic press_pulse
);

   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned WW = $clog2(WINDOW_CYCLES + 1);

   localparam logic [DW-1:0] DMAX  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [WW-1:0] WLOAD = WW'(WINDOW_CYCLES);

   logic          sync1;
   logic          s;
   logic [DW-1:0] dcnt;
   logic [WW-1:0] wcnt;

   // Window is open whenever the countdown has not yet expired.
   assign window_active = (wcnt != '0);

   // Synchroniser, debounce, press qualification and window countdown.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1       <= 1'b0;
         s           <= 1'b0;
         dcnt        <= '0;
         wcnt        <= '0;
         w           <= 1'b0;
         n           <= 1'b0;
         press_pulse <= 1'b0;
      end else begin
         sync1       <= button_raw;
         s           <= sync1;
         press_pulse <= 1'b0;

         if (s == w) begin
            dcnt <= '0;
         end else if (dcnt == DMAX) begin
            w    <= s;
            dcnt <= '0;
            if (s) begin
               // A prompt arriving on the same edge counts as in-window.
               n           <= (wcnt != '0) || prompt;
               press_pulse <= 1'b1;
            end else begin
               n <= 1'b0;
            end
         end else begin
            dcnt <= dcnt + 1'b1;
         end

         if (prompt) begin
            wcnt <= WLOAD;
         end else if (wcnt != '0) begin
            wcnt <= wcnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_press_qualifier.sv
// Directed bench for press_qualifier with DEBOUNCE_CYCLES=4, WINDOW_CYCLES=10.
module tb_press_qualifier;

   logic clock = 1'b0;
   logic reset;
   logic button_raw;
   logic prompt;
   logic w;
   logic n;
   logic window_active;
   logic press_pulse;

   int tests  = 0;
   int failed = 0;

   press_qualifier #(
      .DEBOUNCE_CYCLES(4),
      .WINDOW_CYCLES  (10)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .button_raw   (button_raw),
      .prompt       (prompt),
      .w            (w),
      .n            (n),
      .window_active(window_active),
      .press_pulse  (press_pulse)
   );

   always #5 clock = ~clock;

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      reset      = 1'b1;
      button_raw = 1'b1;
      prompt     = 1'b0;

      // Reset with the button already held.
      step();
      step();
      chk("rst_w", w, 1'b0);
      chk("rst_n", n, 1'b0);
      chk("rst_wa", window_active, 1'b0);
      chk("rst_pp", press_pulse, 1'b0);

      // After reset release, w rises on edge 6 only.
      reset = 1'b0;
      for (int e = 1; e <= 5; e++) begin
         step();
         chk("post_rst_w_low", w, 1'b0);
      end
      step();
      chk("post_rst_w_high", w, 1'b1);
      chk("post_rst_pp", press_pulse, 1'b1);
      chk("post_rst_n", n, 1'b0);
      step();
      chk("post_rst_pp_once", press_pulse, 1'b0);
      chk("post_rst_w_hold", w, 1'b1);

      // Release: w falls on the sixth edge, no pulse.
      button_raw = 1'b0;
      for (int e = 1; e <= 5; e++) begin
         step();
         chk("release_w_hold", w, 1'b1);
      end
      step();
      chk("release_w_low", w, 1'b0);
      chk("release_n", n, 1'b0);
      chk("release_pp", press_pulse, 1'b0);

      // 3-cycle glitch, then 3-high/1-low/3-high bounce: never accepted.
      button_raw = 1'b1;
      repeat (3) step();
      button_raw = 1'b0;
      for (int e = 0; e < 8; e++) begin
         step();
         chk("glitch_w", w, 1'b0);
         chk("glitch_pp", press_pulse, 1'b0);
      end
      button_raw = 1'b1;
      repeat (3) step();
      button_raw = 1'b0;
      step();
      button_raw = 1'b1;
      repeat (3) step();
      button_raw = 1'b0;
      for (int e = 0; e < 10; e++) begin
         step();
         chk("bounce_w", w, 1'b0);
         chk("bounce_n", n, 1'b0);
         chk("bounce_pp", press_pulse, 1'b0);
      end

      // Prompt at cycle 0, w rises at cycle 8 inside the window.
      prompt = 1'b1;
      step();
      for (int c = 1; c <= 17; c++) begin
         prompt = 1'b0;
         if (c == 2)  button_raw = 1'b1;
         if (c == 11) button_raw = 1'b0;
         chk("win_wa", window_active, (c <= 10));
         chk("win_w", w, (c >= 8 && c <= 16));
         chk("win_n", n, (c >= 8 && c <= 16));
         chk("win_pp", press_pulse, (c == 8));
         step();
      end

      // Press rising at cycle 12, after the window closed.
      prompt = 1'b1;
      step();
      for (int c = 1; c <= 18; c++) begin
         prompt = 1'b0;
         if (c == 6)  button_raw = 1'b1;
         if (c == 13) button_raw = 1'b0;
         chk("late_wa", window_active, (c <= 10));
         chk("late_w", w, (c >= 12));
         chk("late_n", n, 1'b0);
         chk("late_pp", press_pulse, (c == 12));
         step();
      end
      chk("late_w_fall", w, 1'b0);

      // Prompt in the cycle w rises, then a reload at cycle 7.
      for (int c = 0; c <= 18; c++) begin
         if (c == 0) button_raw = 1'b1;
         prompt = (c == 5 || c == 7);
         chk("same_w", w, (c >= 6));
         chk("same_n", n, (c >= 6));
         chk("same_pp", press_pulse, (c == 6));
         chk("same_wa", window_active, (c >= 6 && c <= 17));
         step();
      end
      prompt     = 1'b0;
      button_raw = 1'b0;
      repeat (6) step();
      chk("same_rel_w", w, 1'b0);
      chk("same_rel_n", n, 1'b0);

      // Prompt while the button is already held does not qualify it.
      button_raw = 1'b1;
      repeat (6) step();
      chk("held_w", w, 1'b1);
      chk("held_n", n, 1'b0);
      prompt = 1'b1;
      step();
      prompt = 1'b0;
      chk("held_wa", window_active, 1'b1);
      chk("held_n_after_prompt", n, 1'b0);
      repeat (2) step();
      chk("held_n_later", n, 1'b0);
      chk("held_w_later", w, 1'b1);

      // Reset mid-press and mid-window clears everything on the next edge.
      reset = 1'b1;
      step();
      chk("midrst_w", w, 1'b0);
      chk("midrst_n", n, 1'b0);
      chk("midrst_wa", window_active, 1'b0);
      chk("midrst_pp", press_pulse, 1'b0);
      reset = 1'b0;
      for (int e = 1; e <= 5; e++) begin
         step();
         chk("rerise_w_low", w, 1'b0);
      end
      step();
      chk("rerise_w_high", w, 1'b1);
      chk("rerise_pp", press_pulse, 1'b1);
      chk("rerise_n", n, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
